unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two
//  requesters: the core (port c_*) and the debug/program loader (port d_*). Sequences each access
//  over a fixed-latency memory, returns read data and a done pulse, and exposes busy/owner status.
//  Sits between the DataPath memory interface and the memory macro.
// PARAMETERS
//  AW       32  address width (byte address, passed through unmodified)
//  DW       32  data width
//  MEM_LAT  1   memory access cycles, >=1; mem_rdata valid at end of the last ACCESS cycle
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  c_req      in   1   core request; c_we/c_addr/c_wdata held stable until c_done
//  c_we       in   1   core write enable (1=write, 0=read)
//  c_addr     in   AW  core address
//  c_wdata    in   DW  core write data
//  c_gnt      out  1   one-cycle pulse: core request accepted
//  c_done     out  1   one-cycle pulse: core access complete; c_rdata valid this cycle
//  c_rdata    out  DW  core read data (registered)
//  d_req/d_we/d_addr/d_wdata/d_gnt/d_done/d_rdata   same as c_* for debug/loader port
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  busy       out  1   1 whenever state != IDLE
//  owner      out  1   0=core, 1=debug; requester owning current/last transaction
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (gnt, done, rdata, mem_*, busy, owner); RR pointer=core.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE. IDLE: on an edge with any req, pick winner, latch we/addr/wdata,
//    load counter=MEM_LAT, go ACCESS. ACCESS: mem_en=1, mem_we/addr/wdata from latches; counter
//    decrements; at counter==1, capture mem_rdata (reads only) into winner's rdata reg, go DONE.
//    DONE: winner's done=1 for exactly one cycle; go IDLE. No request accepted in ACCESS or DONE.
//  - gnt pulses in the first ACCESS cycle. Latency: req sampled at edge E0 -> done high in cycle
//    E0+MEM_LAT+1. Throughput: one access per MEM_LAT+2 cycles.
//  - mem_* outputs are 0 outside ACCESS. Writes leave rdata unchanged; done still pulses.
//  - rdata regs hold value until that port's next read completes.
//  - Requester dropping req after acceptance: ignored; access completes, done pulses.
//  - Loser of a simultaneous request keeps req high; served on next IDLE sample.
//  - Reset mid-ACCESS/DONE: abort immediately, no done pulse, all outputs to reset values.
//  - Counter width $clog2(MEM_LAT+1); MEM_LAT=1 gives one ACCESS cycle.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, core wins all simultaneous requests.
//  ARB_ROUND_ROBIN_EN defined: 1-bit pointer = last owner; on simultaneous requests the port not
//    served last wins; a lone request always wins; pointer updates on acceptance.
// STRUCTURE
//  - Shared package mem_arb_pkg: state encoding (S_IDLE, S_ACCESS, S_DONE), owner constants
//    OWN_CORE=0, OWN_DBG=1.
//  - One sub-module: mem_arb_pick (combinational winner select from c_req, d_req, pointer;
//    pointer input ignored when ARB_ROUND_ROBIN_EN undefined).
// TESTING
//  1 Reset, MEM_LAT=1: c_req read addr 0x10, mem_rdata=0xDEADBEEF -> c_gnt at E0+1, c_done and
//    c_rdata=0xDEADBEEF at E0+2, mem_en high one cycle only.
//  2 d_req write addr 0x40 data 0x12345678, MEM_LAT=3 -> mem_en/mem_we high 3 cycles with
//    addr/data stable, d_done at E0+4, d_rdata unchanged.
//  3 c_req and d_req high together, both held: fixed priority -> core served, then debug;
//    with ARB_ROUND_ROBIN_EN, four back-to-back wins alternate core,debug,core,debug.
//  4 c_req dropped in cycle after acceptance -> access completes, c_done pulses once.
//  5 rst asserted in ACCESS cycle 2 of MEM_LAT=3 -> next cycle mem_en=0, busy=0, no done pulse;
//    a fresh request after rst completes normally.
//  6 Continuous c_req reads, MEM_LAT=2 -> c_done every 4 cycles; busy low exactly one cycle between.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding and owner codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between core and debug requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority; otherwise the core always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last gets the memory.
    always_comb begin
        valid  = c_req | d_req;
        winner = OWN_CORE;
        if (c_req && d_req) begin
            winner = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
        end else if (d_req) begin
            winner = OWN_DBG;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        valid  = c_req | d_req;
        winner = c_req ? OWN_CORE : (d_req ? OWN_DBG : OWN_CORE);
    end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares the unified instruction/data memory between the core and the debug loader.
// Optional round-robin arbitration is enabled with the ARB_ROUND_ROBIN_EN macro.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          pick_valid;
    logic          pick_winner;
    logic          in_access;
    logic          in_done;
    logic          first_access;

    // The last owner doubles as the round-robin pointer.
    mem_arb_pick u_pick (
        .c_req      (c_req),
        .d_req      (d_req),
        .last_owner (owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_ACCESS;
                    owner_d = pick_winner;
                    cnt_d   = CW'(MEM_LAT);
                    if (pick_winner == OWN_DBG) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = c_we;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            c_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory bus is driven only while an access is in flight.
    always_comb begin
        in_access    = (state_q == S_ACCESS);
        in_done      = (state_q == S_DONE);
        first_access = in_access && (cnt_q == CW'(MEM_LAT));
        mem_en       = in_access;
        mem_we       = in_access && we_q;
        mem_addr     = in_access ? addr_q  : '0;
        mem_wdata    = in_access ? wdata_q : '0;
        c_gnt        = first_access && (owner_q == OWN_CORE);
        d_gnt        = first_access && (owner_q == OWN_DBG);
        c_done       = in_done && (owner_q == OWN_CORE);
        d_done       = in_done && (owner_q == OWN_DBG);
        busy         = (state_q != S_IDLE);
        owner        = owner_q;
        c_rdata      = c_rdata_q;
        d_rdata      = d_rdata_q;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: three instances with MEM_LAT = 1, 2, 3.
module tb_unified_mem_arbiter;

    localparam int N = 3;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req [N];
    logic        c_we [N];
    logic [31:0] c_addr [N];
    logic [31:0] c_wdata [N];
    logic        c_gnt [N];
    logic        c_done [N];
    logic [31:0] c_rdata [N];
    logic        d_req [N];
    logic        d_we [N];
    logic [31:0] d_addr [N];
    logic [31:0] d_wdata [N];
    logic        d_gnt [N];
    logic        d_done [N];
    logic [31:0] d_rdata [N];
    logic        mem_en [N];
    logic        mem_we [N];
    logic [31:0] mem_addr [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        busy [N];
    logic        owner [N];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cycle = 0;
    int          last_done_cycle = 0;
    int          prev_done_cycle = 0;
    exp_t        sb [$];
    logic [31:0] last_rd [N][2];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            assign mem_rdata[g] = mem_model(mem_addr[g]);
            unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(g + 1)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .c_req     (c_req[g]),
                .c_we      (c_we[g]),
                .c_addr    (c_addr[g]),
                .c_wdata   (c_wdata[g]),
                .c_gnt     (c_gnt[g]),
                .c_done    (c_done[g]),
                .c_rdata   (c_rdata[g]),
                .d_req     (d_req[g]),
                .d_we      (d_we[g]),
                .d_addr    (d_addr[g]),
                .d_wdata   (d_wdata[g]),
                .d_gnt     (d_gnt[g]),
                .d_done    (d_done[g]),
                .d_rdata   (d_rdata[g]),
                .mem_en    (mem_en[g]),
                .mem_we    (mem_we[g]),
                .mem_addr  (mem_addr[g]),
                .mem_wdata (mem_wdata[g]),
                .mem_rdata (mem_rdata[g]),
                .busy      (busy[g]),
                .owner     (owner[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_gnt(input int g, input logic p);
        return p ? d_gnt[g] : c_gnt[g];
    endfunction

    function automatic logic sel_done(input int g, input logic p);
        return p ? d_done[g] : c_done[g];
    endfunction

    function automatic logic [31:0] sel_rdata(input int g, input logic p);
        return p ? d_rdata[g] : c_rdata[g];
    endfunction

    task automatic driveReq(input int g, input logic p, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata;
        end else begin
            c_req[g] = 1'b1; c_we[g] = we; c_addr[g] = addr; c_wdata[g] = wdata;
        end
    endtask

    task automatic pushExp(input int g, input logic p, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.owner = p;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = we ? last_rd[g][p] : mem_model(addr);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int g, input logic p, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        driveReq(g, p, we, addr, wdata);
        pushExp(g, p, we, addr, wdata);
    endtask

    // Called in the first ACCESS cycle; follows the transaction through DONE into IDLE.
    task automatic followTxn(input int g, input logic [1:0] drop, input logic [1:0] rel);
        exp_t e;
        string t;
        if (sb.size() == 0) begin
            tests_failed++;
            $error("[TB] FAIL scoreboard_empty g%0d observed=0 expected=1", g);
            return;
        end
        e = sb[0];
        t = $sformatf("g%0d_p%0d_a%0h", g, e.owner, e.addr);
        checkOutput({t, "_gnt"}, 32'(sel_gnt(g, e.owner)), 32'd1);
        checkOutput({t, "_other_gnt"}, 32'(sel_gnt(g, ~e.owner)), 32'd0);
        checkOutput({t, "_owner"}, 32'(owner[g]), 32'(e.owner));
        checkOutput({t, "_busy_acc"}, 32'(busy[g]), 32'd1);
        checkOutput({t, "_mem_en"}, 32'(mem_en[g]), 32'd1);
        checkOutput({t, "_mem_we"}, 32'(mem_we[g]), 32'(e.we));
        checkOutput({t, "_mem_addr"}, mem_addr[g], e.addr);
        if (e.we) checkOutput({t, "_mem_wdata"}, mem_wdata[g], e.wdata);
        if (drop[0]) c_req[g] = 1'b0;
        if (drop[1]) d_req[g] = 1'b0;
        for (int i = 1; i < g + 1; i++) begin
            cyc();
            checkOutput({t, "_mem_en_hold"}, 32'(mem_en[g]), 32'd1);
            checkOutput({t, "_mem_we_hold"}, 32'(mem_we[g]), 32'(e.we));
            checkOutput({t, "_mem_addr_hold"}, mem_addr[g], e.addr);
            if (e.we) checkOutput({t, "_mem_wdata_hold"}, mem_wdata[g], e.wdata);
            checkOutput({t, "_gnt_once"}, 32'(sel_gnt(g, e.owner)), 32'd0);
            checkOutput({t, "_done_early"}, 32'(sel_done(g, e.owner)), 32'd0);
        end
        cyc();
        checkOutput({t, "_done"}, 32'(sel_done(g, e.owner)), 32'd1);
        checkOutput({t, "_other_done"}, 32'(sel_done(g, ~e.owner)), 32'd0);
        checkOutput({t, "_mem_en_off"}, 32'(mem_en[g]), 32'd0);
        checkOutput({t, "_mem_addr_off"}, mem_addr[g], 32'd0);
        checkOutput({t, "_busy_done"}, 32'(busy[g]), 32'd1);
        checkOutput({t, "_rdata"}, sel_rdata(g, e.owner), e.rdata);
        if (!e.we) last_rd[g][e.owner] = e.rdata;
        void'(sb.pop_front());
        prev_done_cycle = last_done_cycle;
        last_done_cycle = cycle;
        if (rel[0]) c_req[g] = 1'b0;
        if (rel[1]) d_req[g] = 1'b0;
        cyc();
        checkOutput({t, "_busy_idle"}, 32'(busy[g]), 32'd0);
        checkOutput({t, "_done_once"}, 32'(sel_done(g, e.owner)), 32'd0);
        checkOutput({t, "_owner_idle"}, 32'(owner[g]), 32'(e.owner));
    endtask

    task automatic checkReset(input string tag);
        for (int g = 0; g < N; g++) begin
            checkOutput($sformatf("%s_g%0d_busy", tag, g), 32'(busy[g]), 32'd0);
            checkOutput($sformatf("%s_g%0d_owner", tag, g), 32'(owner[g]), 32'd0);
            checkOutput($sformatf("%s_g%0d_mem_en", tag, g), 32'(mem_en[g]), 32'd0);
            checkOutput($sformatf("%s_g%0d_mem_addr", tag, g), mem_addr[g], 32'd0);
            checkOutput($sformatf("%s_g%0d_c_rdata", tag, g), c_rdata[g], 32'd0);
            checkOutput($sformatf("%s_g%0d_d_rdata", tag, g), d_rdata[g], 32'd0);
            checkOutput($sformatf("%s_g%0d_done", tag, g), 32'({c_done[g], d_done[g], c_gnt[g], d_gnt[g]}), 32'd0);
            last_rd[g][0] = '0;
            last_rd[g][1] = '0;
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            c_req[g] = 1'b0; c_we[g] = 1'b0; c_addr[g] = '0; c_wdata[g] = '0;
            d_req[g] = 1'b0; d_we[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
        end
        rst = 1'b1;
        repeat (3) cyc();
        checkReset("reset");
        rst = 1'b0;
        cyc();

        // Core read with MEM_LAT=1.
        applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
        cyc();
        followTxn(0, 2'b00, 2'b01);

        // Core drops its request right after acceptance.
        applyStimulus(0, 1'b0, 1'b0, 32'h24, 32'h0);
        cyc();
        followTxn(0, 2'b01, 2'b00);
        cyc();
        checkOutput("drop_no_second_done", 32'(c_done[0]), 32'd0);
        checkOutput("drop_stays_idle", 32'(busy[0]), 32'd0);

        // A debug read leaves the pointer on debug before the contention test.
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
        cyc();
        followTxn(0, 2'b00, 2'b10);

        // Simultaneous requests, both held.
        driveReq(0, 1'b0, 1'b0, 32'h100, 32'h0);
        driveReq(0, 1'b1, 1'b0, 32'h200, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        pushExp(0, 1'b0, 1'b0, 32'h100, 32'h0);
        pushExp(0, 1'b1, 1'b0, 32'h200, 32'h0);
        pushExp(0, 1'b0, 1'b0, 32'h100, 32'h0);
        pushExp(0, 1'b1, 1'b0, 32'h200, 32'h0);
        cyc(); followTxn(0, 2'b00, 2'b00);
        cyc(); followTxn(0, 2'b00, 2'b00);
        cyc(); followTxn(0, 2'b00, 2'b00);
        cyc(); followTxn(0, 2'b00, 2'b11);
`else
        pushExp(0, 1'b0, 1'b0, 32'h100, 32'h0);
        pushExp(0, 1'b1, 1'b0, 32'h200, 32'h0);
        cyc(); followTxn(0, 2'b01, 2'b00);
        cyc(); followTxn(0, 2'b00, 2'b10);
`endif
        cyc();
        checkOutput("contend_idle", 32'(busy[0]), 32'd0);

        // Debug read then debug write, MEM_LAT=3; the write must not disturb d_rdata.
        applyStimulus(2, 1'b1, 1'b0, 32'h44, 32'h0);
        cyc();
        followTxn(2, 2'b00, 2'b10);
        applyStimulus(2, 1'b1, 1'b1, 32'h40, 32'h12345678);
        cyc();
        followTxn(2, 2'b00, 2'b10);

        // Back-to-back core reads, MEM_LAT=2: one done every four cycles.
        driveReq(1, 1'b0, 1'b0, 32'h80, 32'h0);
        pushExp(1, 1'b0, 1'b0, 32'h80, 32'h0);
        pushExp(1, 1'b0, 1'b0, 32'h80, 32'h0);
        pushExp(1, 1'b0, 1'b0, 32'h80, 32'h0);
        cyc(); followTxn(1, 2'b00, 2'b00);
        cyc(); followTxn(1, 2'b00, 2'b00);
        checkOutput("stream_period_1", 32'(last_done_cycle - prev_done_cycle), 32'd4);
        cyc(); followTxn(1, 2'b00, 2'b01);
        checkOutput("stream_period_2", 32'(last_done_cycle - prev_done_cycle), 32'd4);

        // Reset in the second ACCESS cycle aborts the transfer.
        driveReq(2, 1'b0, 1'b0, 32'h30, 32'h0);
        cyc();
        checkOutput("abort_gnt", 32'(c_gnt[2]), 32'd1);
        cyc();
        checkOutput("abort_in_access", 32'(mem_en[2]), 32'd1);
        rst = 1'b1;
        c_req[2] = 1'b0;
        cyc();
        checkReset("abort");
        rst = 1'b0;
        cyc();
        checkOutput("abort_no_done", 32'(c_done[2]), 32'd0);
        checkOutput("abort_idle", 32'(busy[2]), 32'd0);
        applyStimulus(2, 1'b0, 1'b0, 32'h34, 32'h0);
        cyc();
        followTxn(2, 2'b00, 2'b01);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
